// File: rtl/mfp_clock_mode_ctrl_if.sv
// Mode-select bundle between the board-switch side and the clock divider.
// The controller (master) receives requests and drives the divider select and status.
interface mfp_clock_mode_ctrl_if;
  logic [1:0] mode_req;
  logic       lock;
  logic [1:0] mode;
  logic       clk_hold;
  logic       busy;
  logic       changed;

  modport master (
    input  mode_req,
    input  lock,
    output mode,
    output clk_hold,
    output busy,
    output changed
  );

  modport slave (
    output mode_req,
    output lock,
    input  mode,
    input  clk_hold,
    input  busy,
    input  changed
  );
endinterface

// File: rtl/mfp_clock_mode_ctrl.sv
// Synchronises and debounces the board mode switches, then sequences each divider
// mode change as hold -> guard -> switch -> settle -> release.
module mfp_clock_mode_ctrl #(
  parameter logic [1:0]  RESET_MODE      = 2'd0,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned GUARD_CYCLES    = 256,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic                 gclk,
  input  logic                 rst_n,
  mfp_clock_mode_ctrl_if.master ctl
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam logic [CNT_WIDTH-1:0] DB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GUARD_LAST = CNT_WIDTH'(GUARD_CYCLES - 1);

  logic [1:0]           sync1;
  logic [1:0]           req_s;
  logic [1:0]           cand;
  logic [1:0]           db_mode;
  logic [CNT_WIDTH-1:0] dcnt;

  logic [1:0]           state;
  logic [1:0]           target;
  logic [CNT_WIDTH-1:0] gcnt;
  logic [1:0]           mode_r;
  logic                 clk_hold_r;
  logic                 busy_r;
  logic                 changed_r;

  // Two-flop synchroniser followed by a saturating run-length debounce.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= RESET_MODE;
      req_s   <= RESET_MODE;
      cand    <= RESET_MODE;
      db_mode <= RESET_MODE;
      dcnt    <= '0;
    end else begin
      sync1 <= ctl.mode_req;
      req_s <= sync1;
      if (req_s != cand) begin
        cand <= req_s;
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        db_mode <= cand;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      target     <= RESET_MODE;
      gcnt       <= '0;
      mode_r     <= RESET_MODE;
      clk_hold_r <= 1'b0;
      busy_r     <= 1'b0;
      changed_r  <= 1'b0;
    end else begin
      changed_r <= 1'b0;
      case (state)
        S_IDLE: begin
          // target is latched here so later switch activity cannot alter this change
          if (db_mode != mode_r && !ctl.lock) begin
            target     <= db_mode;
            gcnt       <= '0;
            clk_hold_r <= 1'b1;
            busy_r     <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (gcnt == GUARD_LAST) begin
            gcnt  <= '0;
            state <= S_SWITCH;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        S_SWITCH: begin
          mode_r <= target;
          state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (gcnt == GUARD_LAST) begin
            gcnt       <= '0;
            clk_hold_r <= 1'b0;
            busy_r     <= 1'b0;
            changed_r  <= 1'b1;
            state      <= S_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ctl.mode     = mode_r;
  assign ctl.clk_hold = clk_hold_r;
  assign ctl.busy     = busy_r;
  assign ctl.changed  = changed_r;

endmodule
